// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO read-side stream adapter
//
// Purpose : buffer state encoding and buffer depth used by fifo_rd_stream.
// Ports   : none (package).

package fifo_rd_pkg;

  // Number of words held by the output buffer (HEAD + TAIL).
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - show-ahead FIFO read port to registered valid/ready stream
//
// Purpose : pops words from a show-ahead FIFO read port into a 2-entry
//           HEAD/TAIL buffer and presents HEAD as a registered stream.
//           Provides a synchronous flush and a wrapping delivered-word count.
// Ports   : rdclk, rdrst_n      - read-domain clock, async active-low reset
//           fifo_empty/fifo_data - FIFO show-ahead read port inputs
//           fifo_rd_en          - pop strobe to the FIFO
//           m_valid/m_data      - registered output stream
//           m_ready             - downstream accept
//           flush               - discard buffered words this cycle
//           word_count          - words delivered since reset (wraps)

module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   rdclk,
  input  logic                   rdrst_n,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  input  logic                   flush,
  output logic [COUNT_WIDTH-1:0] word_count
);

  rd_state_e              r_state;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_head;
  logic [DATA_WIDTH-1:0]  r_tail;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_pop;
  logic w_take;

  // Pop decision depends only on flops and FIFO/flush inputs, never on
  // m_ready; the reset term keeps the strobe low while reset is held.
  assign w_pop  = rdrst_n & ~fifo_empty & (r_state != S_TWO) & ~flush;
  assign w_take = r_valid & m_ready;

  assign fifo_rd_en = w_pop;
  assign m_valid    = r_valid;
  assign m_data     = r_head;
  assign word_count = r_count;

  always_ff @(posedge rdclk or negedge rdrst_n) begin
    if (!rdrst_n) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // A take coinciding with flush is a real delivery and still counts.
      if (w_take) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end

      if (flush) begin
        r_state <= S_EMPTY;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_pop) begin
              r_head  <= fifo_data;
              r_state <= S_ONE;
              r_valid <= 1'b1;
            end
          end
          S_ONE: begin
            if (w_pop && !w_take) begin
              r_tail  <= fifo_data;
              r_state <= S_TWO;
            end else if (w_take && !w_pop) begin
              r_state <= S_EMPTY;
              r_valid <= 1'b0;
            end else if (w_pop && w_take) begin
              // HEAD is vacated this cycle with no TAIL: refill it directly.
              r_head <= fifo_data;
            end
          end
          S_TWO: begin
            if (w_take) begin
              r_head  <= r_tail;
              r_state <= S_ONE;
            end
          end
          default: begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer adapter for the asynchronous FIFO: runs in the FIFO's read clock domain, pops words through the FIFO's show-ahead read port (`fifo_empty` / `rd_en` / `data_out`) and re-presents them as a registered valid/ready stream. A 2-entry output buffer decouples downstream back-pressure from the FIFO pop and gives one word per cycle sustained throughput. It also provides a synchronous flush and a running count of delivered words.

## Interface
- `DATA_WIDTH`, 8, word width; must equal the FIFO's `DATA_WIDTH`.
- `COUNT_WIDTH`, 16, width of the delivered-word counter.

- `rdclk`  in  1  read-domain clock; the only clock.
- `rdrst_n`  in  1  reset, asynchronous assert, active-low.
- `fifo_empty`  in  1  FIFO empty flag (registered in the FIFO).
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid whenever `fifo_empty`=0.
- `fifo_rd_en`  out  1  pop strobe to the FIFO `rd_en`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  downstream accept.
- `flush`  in  1  synchronous discard of the buffered words.
- `word_count`  out  COUNT_WIDTH  words delivered (`m_valid & m_ready`) since reset.

## Operation
- Buffer: two entries, HEAD and TAIL, plus state `S_EMPTY` (0 words), `S_ONE` (1 word), `S_TWO` (2 words). `m_data` = HEAD and `m_valid` = (state != `S_EMPTY`), both taken directly from flops.
- Pop rule: `fifo_rd_en` = `!fifo_empty & (state != S_TWO) & !flush`. There is no combinational path from `m_ready` to `fifo_rd_en`.
- On a pop, `fifo_data` is captured the same edge. It goes to HEAD if HEAD is free, or is being vacated this cycle with no TAIL. Otherwise it goes to TAIL.
- Transitions (pop = `fifo_rd_en`, take = `m_valid & m_ready`):
  - `S_EMPTY`: pop → `S_ONE`; otherwise stay.
  - `S_ONE`: pop & !take → `S_TWO`; take & !pop → `S_EMPTY`; pop & take → `S_ONE` (HEAD ← `fifo_data`); neither → stay.
  - `S_TWO`: take → `S_ONE` (HEAD ← TAIL); otherwise stay. No pop occurs in this state.
- Flush: with `flush`=1 the next state is `S_EMPTY`. No pop occurs that cycle. A take in the same cycle still counts.
- `word_count` increments by 1 per take and wraps modulo 2^COUNT_WIDTH. Flush does not clear it.
- `m_data` stays stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset values: state=`S_EMPTY`, `m_valid`=0, `m_data`=0, HEAD=TAIL=0, `word_count`=0, `fifo_rd_en`=0 (forced low while `rdrst_n`=0).
- Latency: a word that is visible with `fifo_empty`=0 at edge N appears on `m_data` with `m_valid`=1 after edge N (first-word latency 1 cycle).
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word per cycle in steady state `S_ONE`.
- Back-pressure: `m_ready`=0 for k≥2 cycles fills the buffer. Popping stops after at most 2 words; `fifo_rd_en` is 0 in `S_TWO`.
- FIFO empty: `fifo_rd_en` is never asserted while `fifo_empty`=1. Over-read is impossible by construction.
- Reset mid-operation: buffered words are lost and the counter clears. Pointer consistency with the FIFO requires resetting both domains together.

## Structure
- Package `fifo_rd_pkg` holds:
  - the state typedef (`S_EMPTY`, `S_ONE`, `S_TWO`, 2-bit encoding 0/1/2);
  - a `BUF_DEPTH`=2 constant.
- A single module; no sub-module. The 2-entry buffer and its control form one FSM and stay together.

## Test plan
- Reset: assert `rdrst_n`=0 with `fifo_empty`=0 and `m_ready`=1 → `m_valid`=0, `fifo_rd_en`=0, `word_count`=0 throughout reset. First pop occurs on the first edge after release.
- Streaming: FIFO preloaded with 0x01..0x10, `m_ready`=1 → `m_data` = 0x01..0x10 on 16 consecutive cycles, `word_count`=16, `fifo_rd_en` deasserts once `fifo_empty`=1.
- Back-pressure: FIFO holds 0xA0..0xA7, `m_ready`=0 for 5 cycles → exactly 2 pops, `m_data`=0xA0 stable, state `S_TWO`. Releasing `m_ready` then delivers 0xA0..0xA7 in order with no gaps after the first word.
- Flush: state `S_TWO` holding 0x55, 0x66, pulse `flush` one cycle with `m_ready`=0 → `m_valid`=0 next cycle, no pop that cycle. Next word delivered is the FIFO's following entry; `word_count` is unchanged.
- Counter wrap: COUNT_WIDTH=4, deliver 17 words → `word_count`=1.
- Random back-pressure: random `m_ready` and random FIFO fill over 1000 words → output sequence equals input sequence, `fifo_rd_en` never high while `fifo_empty`=1, `m_data` stable whenever stalled.
